// File: rtl/bin_capture_scheduler_if.sv
// Bundle of the FFT frame strobes, software configuration, capture qualifiers
// and dump handshake that run between bin_capture_scheduler and its neighbours.
interface bin_capture_scheduler_if #(
  parameter int BIN_W = 10,
  parameter int AVG_W = 4
);
  logic             fft_valid;
  logic             start;
  logic             stop;
  logic [BIN_W-1:0] cfg_start_bin;
  logic [BIN_W:0]   cfg_num_bins;
  logic [AVG_W-1:0] cfg_log2_avgs;
  logic             cap_en;
  logic [BIN_W-1:0] cap_bin_idx;
  logic             first_frame;
  logic             last_frame;
  logic             dump_valid;
  logic             dump_ready;
  logic             busy;
  logic             cfg_err;
  logic             overrun;

  modport master (
    output fft_valid, start, stop, cfg_start_bin, cfg_num_bins, cfg_log2_avgs, dump_ready,
    input  cap_en, cap_bin_idx, first_frame, last_frame, dump_valid, busy, cfg_err, overrun
  );

  modport slave (
    input  fft_valid, start, stop, cfg_start_bin, cfg_num_bins, cfg_log2_avgs, dump_ready,
    output cap_en, cap_bin_idx, first_frame, last_frame, dump_valid, busy, cfg_err, overrun
  );
endinterface

// File: rtl/bin_capture_scheduler.sv
// Schedules a capture window over a contiguous bin range of each FFT frame and
// groups 2^log2_avgs frames into one average, ending each average with a dump request.
module bin_capture_scheduler #(
  parameter int FFT_LEN = 1024,
  parameter int BIN_W   = $clog2(FFT_LEN),
  parameter int AVG_W   = 4
) (
  input  logic                   clk_i,
  input  logic                   areset_n_i,
  bin_capture_scheduler_if.slave bus_if
);
  localparam int FW = (1 << AVG_W) - 1;
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(FFT_LEN - 1);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, WAIT_FRAME, DUMP} state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_cnt_q, cur_bin;
  logic [FW-1:0]    frm_q, frm_d, frm_eff, frm_max;
  logic [BIN_W-1:0] start_bin_q, start_bin_d;
  logic [BIN_W:0]   num_q, num_d, win_last;
  logic [AVG_W-1:0] log2_q, log2_d;
  logic             stop_q, stop_d;
  logic             overrun_q, overrun_d;
  logic             cap_en_q, cap_en_d;
  logic [BIN_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             dump_valid_q, busy_q;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_bad, new_frame, capture;

  // Index of the sample presented this cycle; fft_valid marks bin 0.
  assign cur_bin  = bus_if.fft_valid ? '0 :
                    (bin_cnt_q == BIN_LAST) ? BIN_LAST : bin_cnt_q + BIN_W'(1);
  assign win_last = {1'b0, start_bin_q} + num_q - (BIN_W+1)'(1);
  assign frm_max  = (FW'(1) << log2_q) - FW'(1);
  assign cfg_bad  = (bus_if.cfg_num_bins == '0) ||
                    (({1'b0, bus_if.cfg_num_bins} + {2'b0, bus_if.cfg_start_bin}) > (BIN_W+2)'(FFT_LEN));

  always_comb begin
    state_d     = state_q;
    frm_d       = frm_q;
    frm_eff     = frm_q;
    stop_d      = stop_q;
    overrun_d   = overrun_q;
    start_bin_d = start_bin_q;
    num_d       = num_q;
    log2_d      = log2_q;
    cfg_err_d   = 1'b0;
    cap_en_d    = 1'b0;
    idx_d       = '0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    new_frame   = 1'b0;
    capture     = 1'b0;
    if (state_q != IDLE && bus_if.stop) stop_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            start_bin_d = bus_if.cfg_start_bin;
            num_d       = bus_if.cfg_num_bins;
            log2_d      = bus_if.cfg_log2_avgs;
            overrun_d   = 1'b0;
            frm_d       = '0;
            stop_d      = bus_if.stop;
            state_d     = ARMED;
          end
        end
      end
      ARMED: begin
        if ((stop_q || bus_if.stop) && frm_q == '0) begin
          stop_d  = 1'b0;
          state_d = IDLE;
        end else if (bus_if.fft_valid) begin
          new_frame = 1'b1;
        end
      end
      WAIT_FRAME, CAPTURE: begin
        // A frame strobe before the window closed restarts the average from frame 0.
        if (bus_if.fft_valid) begin
          overrun_d = 1'b1;
          frm_eff   = '0;
          new_frame = 1'b1;
        end else if (state_q == CAPTURE || cur_bin == start_bin_q) begin
          capture = 1'b1;
        end
      end
      DUMP: begin
        if (bus_if.fft_valid) overrun_d = 1'b1;
        if (dump_valid_q && bus_if.dump_ready) begin
          frm_d = '0;
          if (stop_q || bus_if.stop) begin
            stop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = ARMED;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_frame) begin
      frm_d = frm_eff;
      if (start_bin_q == '0) capture = 1'b1;
      else                   state_d = WAIT_FRAME;
    end

    if (capture) begin
      cap_en_d = 1'b1;
      idx_d    = cur_bin - start_bin_q;
      first_d  = (frm_eff == '0);
      last_d   = (frm_eff == frm_max);
      if ({1'b0, cur_bin} == win_last) begin
        if (last_d) begin
          state_d = DUMP;
        end else begin
          frm_d   = frm_eff + FW'(1);
          state_d = ARMED;
        end
      end else begin
        state_d = CAPTURE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state_q      <= IDLE;
      bin_cnt_q    <= '0;
      frm_q        <= '0;
      start_bin_q  <= '0;
      num_q        <= '0;
      log2_q       <= '0;
      stop_q       <= 1'b0;
      overrun_q    <= 1'b0;
      cap_en_q     <= 1'b0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      dump_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= cur_bin;
      frm_q        <= frm_d;
      start_bin_q  <= start_bin_d;
      num_q        <= num_d;
      log2_q       <= log2_d;
      stop_q       <= stop_d;
      overrun_q    <= overrun_d;
      cap_en_q     <= cap_en_d;
      idx_q        <= idx_d;
      first_q      <= first_d;
      last_q       <= last_d;
      dump_valid_q <= (state_d == DUMP);
      busy_q       <= (state_d != IDLE);
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus_if.cap_en      = cap_en_q;
  assign bus_if.cap_bin_idx = idx_q;
  assign bus_if.first_frame = first_q;
  assign bus_if.last_frame  = last_q;
  assign bus_if.dump_valid  = dump_valid_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.cfg_err     = cfg_err_q;
  assign bus_if.overrun     = overrun_q;
endmodule

// File: tb/tb_bin_capture_scheduler.sv
// Directed bench for bin_capture_scheduler with a 16-bin FFT; outputs are
// sampled 1 ns after each rising edge and compared as one packed vector.
module tb_bin_capture_scheduler;
  localparam int BW = 4;

  logic clk;
  logic areset_n;
  int   nAssert;
  int   nFail;
  int   tbSb;
  int   tbNb;

  bin_capture_scheduler_if #(.BIN_W(BW), .AVG_W(4)) busIf ();

  bin_capture_scheduler #(.FFT_LEN(16), .BIN_W(BW), .AVG_W(4)) dut (
    .clk_i      (clk),
    .areset_n_i (areset_n),
    .bus_if     (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Vector layout: {cap_en, cap_bin_idx[3:0], first, last, dump_valid, busy, cfg_err, overrun}
  task automatic checkOutput(input string tag, input logic [10:0] expVec);
    logic [10:0] obs;
    obs = {busIf.cap_en, busIf.cap_bin_idx, busIf.first_frame, busIf.last_frame,
           busIf.dump_valid, busIf.busy, busIf.cfg_err, busIf.overrun};
    nAssert++;
    assert (obs === expVec) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expVec);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic st, input logic sp);
    busIf.fft_valid = fv;
    busIf.start     = st;
    busIf.stop      = sp;
    @(posedge clk);
    #1;
    busIf.fft_valid = 1'b0;
    busIf.start     = 1'b0;
    busIf.stop      = 1'b0;
  endtask

  task automatic setCfg(input int sb, input int nb, input int lg);
    busIf.cfg_start_bin = BW'(sb);
    busIf.cfg_num_bins  = (BW+1)'(nb);
    busIf.cfg_log2_avgs = 4'(lg);
    tbSb = sb;
    tbNb = nb;
  endtask

  // One frame of len samples starting with an fft_valid strobe; expectations follow the window.
  task automatic frameRun(input string tag, input int len, input bit capOn, input bit expFirst,
                          input bit expLast, input int dvFrom, input bit dvHold, input int stopAt,
                          input int busyEnd, input bit expOvr);
    logic [10:0] expVec;
    bit          inWin;
    for (int b = 0; b < len; b++) begin
      applyStimulus(b == 0, 1'b0, b == stopAt);
      inWin  = capOn && (b >= tbSb) && (b < tbSb + tbNb);
      expVec = {inWin, inWin ? 4'(b - tbSb) : 4'd0, inWin && expFirst, inWin && expLast,
                dvHold ? (b >= dvFrom) : (b == dvFrom), b < busyEnd, 1'b0, expOvr};
      checkOutput($sformatf("%s b%0d", tag, b), expVec);
    end
  endtask

  initial begin
    nAssert = 0;
    nFail   = 0;
    areset_n = 1'b0;
    busIf.fft_valid  = 1'b0;
    busIf.start      = 1'b0;
    busIf.stop       = 1'b0;
    busIf.dump_ready = 1'b1;
    setCfg(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 11'b0);
    areset_n = 1'b1;

    $display("[TB] config rejection");
    setCfg(14, 3, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("err_overflow", 11'b0000_0000_010);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("err_pulse_end", 11'b0);
    setCfg(2, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("err_zero_len", 11'b0000_0000_010);

    $display("[TB] two-frame averages, window 4..6");
    setCfg(4, 3, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start_a", 11'b0000_0000_100);
    frameRun("a_f0", 16, 1, 1, 0, 16, 0, 16, 16, 0);
    frameRun("a_f1", 16, 1, 0, 1, 6, 0, 16, 16, 0);
    frameRun("a_f2", 16, 1, 1, 0, 16, 0, 16, 16, 0);
    busIf.dump_ready = 1'b0;
    frameRun("hold_f3", 16, 1, 0, 1, 6, 1, 16, 16, 0);
    frameRun("hold_drop", 16, 0, 0, 0, 0, 1, 16, 16, 1);
    busIf.dump_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_accept", 11'b0000_0000_101);
    frameRun("resume", 16, 1, 1, 0, 16, 0, 16, 16, 1);
    frameRun("stop_last", 16, 1, 0, 1, 6, 0, 2, 7, 1);
    frameRun("idle_a", 16, 0, 0, 0, 16, 0, 16, 0, 1);

    $display("[TB] stop in frame 0 of a four-frame average");
    setCfg(4, 3, 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start_b", 11'b0000_0000_100);
    frameRun("b_f0", 16, 1, 1, 0, 16, 0, 5, 16, 0);
    frameRun("b_f1", 16, 1, 0, 0, 16, 0, 16, 16, 0);
    frameRun("b_f2", 16, 1, 0, 0, 16, 0, 16, 16, 0);
    frameRun("b_f3", 16, 1, 0, 1, 6, 0, 16, 7, 0);
    frameRun("idle_b", 16, 0, 0, 0, 16, 0, 16, 0, 0);

    $display("[TB] short frame inside window 4..8");
    setCfg(4, 5, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start_c", 11'b0000_0000_100);
    frameRun("short", 6, 1, 1, 0, 16, 0, 16, 16, 0);
    frameRun("after_short", 16, 1, 1, 0, 16, 0, 16, 16, 1);
    frameRun("c_last", 16, 1, 0, 1, 8, 0, 16, 16, 1);

    $display("[TB] async reset during capture");
    frameRun("pre_reset", 6, 1, 1, 0, 16, 0, 16, 16, 1);
    #2;
    areset_n = 1'b0;
    #1;
    checkOutput("reset_async", 11'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_edge", 11'b0);
    areset_n = 1'b1;

    $display("[TB] window at frame end, one frame per average");
    setCfg(13, 3, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start_d", 11'b0000_0000_100);
    frameRun("d_f0", 16, 1, 1, 1, 15, 0, 16, 16, 0);
    frameRun("d_drop", 16, 0, 0, 0, 16, 0, 16, 16, 1);
    frameRun("d_f1", 16, 1, 1, 1, 15, 0, 16, 16, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("d_accept", 11'b0000_0000_101);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
